// File: rtl/alarm_sequencer_if.sv
// Control/status bundle between the alarm sequencer and its surroundings.
// The master side drives the tick, switch, match and button inputs; the slave side is the sequencer.
interface alarm_sequencer_if #(
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZES    = 3
);
    localparam int CW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;
    localparam int RW = $clog2(SNOOZE_SECONDS + 1);

    logic          i_Tick_1Hz_Pulse;
    logic          i_Alarm_Enable;
    logic          i_Time_Match;
    logic          i_Snooze;
    logic          i_Dismiss;
    logic [1:0]    o_State;
    logic          o_Alarm_On;
    logic          o_Alarm_Enabled;
    logic [CW-1:0] o_Snooze_Count;
    logic [RW-1:0] o_Snooze_Remaining;

    modport master (
        output i_Tick_1Hz_Pulse, i_Alarm_Enable, i_Time_Match, i_Snooze, i_Dismiss,
        input  o_State, o_Alarm_On, o_Alarm_Enabled, o_Snooze_Count, o_Snooze_Remaining
    );

    modport slave (
        input  i_Tick_1Hz_Pulse, i_Alarm_Enable, i_Time_Match, i_Snooze, i_Dismiss,
        output o_State, o_Alarm_On, o_Alarm_Enabled, o_Snooze_Count, o_Snooze_Remaining
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm arm/ring/snooze/dismiss controller on the 1 Hz tick.
// Ring auto-timeout is built only when ALARM_SEQUENCER_RING_TIMEOUT_EN is defined.
//
// state     | meaning
// DISABLED  | alarm switch off, all counters held at 0
// ARMED     | waiting for a rising edge of time match
// RINGING   | alarm output on
// SNOOZING  | alarm silenced, counting down to ring again
module alarm_sequencer #(
    parameter int SNOOZE_SECONDS       = 300,
    parameter int RING_TIMEOUT_SECONDS = 60,
    parameter int MAX_SNOOZES          = 3
) (
    input logic               i_Clk,
    input logic               i_Reset,
    alarm_sequencer_if.slave  bus
);
    localparam int CW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;
    localparam int RW = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [CW-1:0] MAX_COUNT   = CW'(MAX_SNOOZES);
    localparam logic [RW-1:0] SNOOZE_LOAD = RW'(SNOOZE_SECONDS);

    generate
        if (SNOOZE_SECONDS < 1) begin : g_bad_snooze
            $error("SNOOZE_SECONDS must be at least 1");
        end
        if (RING_TIMEOUT_SECONDS < 1) begin : g_bad_ring
            $error("RING_TIMEOUT_SECONDS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] snooze_count_q, snooze_count_d;
    logic [RW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic          match_prev_q, match_prev_d;
    logic          alarm_on_q, alarm_on_d;
    logic          enabled_q, enabled_d;
    logic          match_edge;

`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
    localparam int TW = $clog2(RING_TIMEOUT_SECONDS + 1);
    localparam logic [TW-1:0] RING_LOAD = TW'(RING_TIMEOUT_SECONDS);
    logic [TW-1:0] ring_cnt_q, ring_cnt_d;
`endif

    // match_prev resets high so a match already present at enable never rings
    assign match_edge = bus.i_Time_Match & ~match_prev_q;

    always_comb begin
        state_d        = state_q;
        snooze_count_d = snooze_count_q;
        snooze_cnt_d   = snooze_cnt_q;
        match_prev_d   = bus.i_Time_Match;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
        ring_cnt_d     = ring_cnt_q;
`endif
        if (!bus.i_Alarm_Enable) begin
            state_d        = ST_DISABLED;
            snooze_count_d = '0;
            snooze_cnt_d   = '0;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
            ring_cnt_d     = '0;
`endif
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match_edge) begin
                        state_d = ST_RINGING;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
                        ring_cnt_d = RING_LOAD;
`endif
                    end
                end
                ST_RINGING: begin
                    if (bus.i_Dismiss) begin
                        state_d        = ST_ARMED;
                        snooze_count_d = '0;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
                        ring_cnt_d     = '0;
`endif
                    end else if (bus.i_Snooze && (snooze_count_q < MAX_COUNT)) begin
                        state_d        = ST_SNOOZING;
                        snooze_cnt_d   = SNOOZE_LOAD;
                        snooze_count_d = snooze_count_q + CW'(1);
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
                        ring_cnt_d     = '0;
`endif
                    end
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
                    else if (bus.i_Tick_1Hz_Pulse) begin
                        if (ring_cnt_q == TW'(1)) begin
                            state_d        = ST_ARMED;
                            snooze_count_d = '0;
                            ring_cnt_d     = '0;
                        end else if (ring_cnt_q != '0) begin
                            ring_cnt_d = ring_cnt_q - TW'(1);
                        end
                    end
`endif
                end
                ST_SNOOZING: begin
                    if (bus.i_Dismiss) begin
                        state_d        = ST_ARMED;
                        snooze_count_d = '0;
                        snooze_cnt_d   = '0;
                    end else if (bus.i_Tick_1Hz_Pulse) begin
                        if (snooze_cnt_q == RW'(1)) begin
                            state_d      = ST_RINGING;
                            snooze_cnt_d = '0;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
                            ring_cnt_d   = RING_LOAD;
`endif
                        end else if (snooze_cnt_q != '0) begin
                            snooze_cnt_d = snooze_cnt_q - RW'(1);
                        end
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
        alarm_on_d = (state_d == ST_RINGING);
        enabled_d  = (state_d != ST_DISABLED);
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q        <= ST_DISABLED;
            snooze_count_q <= '0;
            snooze_cnt_q   <= '0;
            match_prev_q   <= 1'b1;
            alarm_on_q     <= 1'b0;
            enabled_q      <= 1'b0;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
            ring_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            snooze_count_q <= snooze_count_d;
            snooze_cnt_q   <= snooze_cnt_d;
            match_prev_q   <= match_prev_d;
            alarm_on_q     <= alarm_on_d;
            enabled_q      <= enabled_d;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
            ring_cnt_q     <= ring_cnt_d;
`endif
        end
    end

    assign bus.o_State            = state_q;
    assign bus.o_Alarm_On         = alarm_on_q;
    assign bus.o_Alarm_Enabled    = enabled_q;
    assign bus.o_Snooze_Count     = snooze_count_q;
    assign bus.o_Snooze_Remaining = snooze_cnt_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: a reference model queues expected outputs per driven cycle.
// Follows ALARM_SEQUENCER_RING_TIMEOUT_EN to select timeout or no-timeout expectations.
module tb_alarm_sequencer;
    localparam int SNZ  = 3;
    localparam int RING = 2;
    localparam int MAXS = 2;
`ifdef ALARM_SEQUENCER_RING_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #100 clk = ~clk;

    alarm_sequencer_if #(.SNOOZE_SECONDS(SNZ), .MAX_SNOOZES(MAXS)) aif();

    alarm_sequencer #(
        .SNOOZE_SECONDS(SNZ),
        .RING_TIMEOUT_SECONDS(RING),
        .MAX_SNOOZES(MAXS)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst_n),
        .bus    (aif.slave)
    );

    typedef struct {
        int st;
        int on;
        int en;
        int cnt;
        int rem;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_st, m_cnt, m_rem, m_ring;
    bit m_prev;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_rem = 0; m_ring = 0; m_prev = 1'b1;
    endtask

    task automatic m_step(input bit tk, input bit en, input bit mt, input bit sn, input bit di);
        bit edge_seen;
        edge_seen = mt && !m_prev;
        m_prev    = mt;
        if (!en) begin
            m_st = 0; m_cnt = 0; m_rem = 0; m_ring = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (edge_seen) begin m_st = 2; m_ring = RING; end
                2: begin
                    if (di) begin
                        m_st = 1; m_cnt = 0;
                    end else if (sn && m_cnt < MAXS) begin
                        m_st = 3; m_rem = SNZ; m_cnt = m_cnt + 1;
                    end else if (tk && TO_EN) begin
                        if (m_ring == 1) begin m_st = 1; m_cnt = 0; end
                        else m_ring = m_ring - 1;
                    end
                end
                default: begin
                    if (di) begin
                        m_st = 1; m_cnt = 0; m_rem = 0;
                    end else if (tk) begin
                        if (m_rem == 1) begin m_st = 2; m_ring = RING; m_rem = 0; end
                        else m_rem = m_rem - 1;
                    end
                end
            endcase
        end
    endtask

    function automatic exp_t m_out();
        exp_t e;
        e.st  = m_st;
        e.on  = (m_st == 2) ? 1 : 0;
        e.en  = (m_st != 0) ? 1 : 0;
        e.cnt = m_cnt;
        e.rem = m_rem;
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".state"},     int'(aif.o_State),            e.st);
        chk({tag, ".alarm_on"},  int'(aif.o_Alarm_On),         e.on);
        chk({tag, ".enabled"},   int'(aif.o_Alarm_Enabled),    e.en);
        chk({tag, ".count"},     int'(aif.o_Snooze_Count),     e.cnt);
        chk({tag, ".remaining"}, int'(aif.o_Snooze_Remaining), e.rem);
    endtask

    task automatic cyc(input bit tk, input bit en, input bit mt, input bit sn, input bit di);
        exp_t e;
        @(negedge clk);
        aif.i_Tick_1Hz_Pulse = tk;
        aif.i_Alarm_Enable   = en;
        aif.i_Time_Match     = mt;
        aif.i_Snooze         = sn;
        aif.i_Dismiss        = di;
        m_step(tk, en, mt, sn, di);
        exp_q.push_back(m_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_outs("cyc", e);
        end
    endtask

    initial begin
        bit r_en, r_mt;
        aif.i_Tick_1Hz_Pulse = 1'b0;
        aif.i_Alarm_Enable   = 1'b0;
        aif.i_Time_Match     = 1'b1;
        aif.i_Snooze         = 1'b0;
        aif.i_Dismiss        = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", m_out());
        @(negedge clk);
        rst_n = 1'b1;

        // enable with match already high: armed, no ring until a fresh edge
        repeat (3) cyc(0, 1, 1, 0, 0);
        chk("armed_no_ring", int'(aif.o_State), 1);
        chk("armed_alarm_off", int'(aif.o_Alarm_On), 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("ring_on_edge", int'(aif.o_State), 2);

        // first snooze and its expiry
        cyc(0, 1, 1, 1, 0);
        chk("snooze1_state", int'(aif.o_State), 3);
        chk("snooze1_count", int'(aif.o_Snooze_Count), 1);
        chk("snooze1_rem", int'(aif.o_Snooze_Remaining), 3);
        cyc(1, 1, 1, 0, 0);
        chk("snooze_rem2", int'(aif.o_Snooze_Remaining), 2);
        cyc(1, 1, 1, 0, 0);
        chk("snooze_rem1", int'(aif.o_Snooze_Remaining), 1);
        cyc(1, 1, 1, 0, 0);
        chk("snooze_expire_state", int'(aif.o_State), 2);
        chk("snooze_expire_rem", int'(aif.o_Snooze_Remaining), 0);

        // second snooze, then the snooze limit
        cyc(0, 1, 1, 1, 0);
        repeat (3) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        chk("snooze_limit_state", int'(aif.o_State), 2);
        chk("snooze_limit_count", int'(aif.o_Snooze_Count), 2);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        if (TO_EN) begin
            chk("timeout_state", int'(aif.o_State), 1);
            chk("timeout_count", int'(aif.o_Snooze_Count), 0);
        end else begin
            repeat (8) cyc(1, 1, 1, 0, 0);
            chk("no_timeout_state", int'(aif.o_State), 2);
            cyc(0, 1, 1, 0, 1);
            chk("dismiss_state", int'(aif.o_State), 1);
        end

        // snooze and dismiss together: dismiss wins
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 1);
        chk("snz_dis_state", int'(aif.o_State), 1);
        chk("snz_dis_count", int'(aif.o_Snooze_Count), 0);

        // snooze with the timeout tick wins; dismiss with the expiry tick arms
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 0);
        chk("snz_vs_timeout", int'(aif.o_State), 3);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 1);
        chk("dis_vs_expiry", int'(aif.o_State), 1);
        chk("dis_vs_expiry_rem", int'(aif.o_Snooze_Remaining), 0);

        // disable while snoozing
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(1, 1, 1, 0, 0);
        chk("pre_disable_rem", int'(aif.o_Snooze_Remaining), 2);
        cyc(0, 0, 1, 0, 0);
        chk("disable_state", int'(aif.o_State), 0);
        chk("disable_enabled", int'(aif.o_Alarm_Enabled), 0);
        chk("disable_count", int'(aif.o_Snooze_Count), 0);
        chk("disable_rem", int'(aif.o_Snooze_Remaining), 0);

        // re-enable with match high, ring, then asynchronous reset mid-cycle
        repeat (3) cyc(0, 1, 1, 0, 0);
        chk("reenable_armed", int'(aif.o_State), 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("reenable_ring", int'(aif.o_State), 2);
        @(negedge clk);
        #20;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outs("async_reset", m_out());
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic against the model
        r_en = 1'b1;
        r_mt = 1'b1;
        repeat (300) begin
            r_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) r_mt = ~r_mt;
            cyc(($urandom_range(0, 2) == 0), r_en, r_mt,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
